// File: rtl/apb_ram_arbiter.sv
// Two-requester APB master sharing one RAM slave with round-robin arbitration.
// Optional ACCESS-phase timeout abort is enabled by defining APB_ARB_TIMEOUT_EN.
module apb_ram_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        done0,
  output logic        done1,
  output logic        err,
  output logic [15:0] rdata,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [15:0] paddr,
  output logic [15:0] pwdata,
  input  logic        pready,
  input  logic [15:0] prdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_owner_q, last_owner_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        grant_s;
  logic        abort_s;
  logic        done_s;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;

  logic [CW-1:0] tcnt_q, tcnt_d;

  // Wait-state counter: cleared in SETUP so it starts at zero on ACCESS entry.
  always_comb begin
    tcnt_d = tcnt_q;
    if (state_q == SETUP) begin
      tcnt_d = '0;
    end else if ((state_q == ACCESS) && !pready) begin
      tcnt_d = tcnt_q + 1'b1;
    end else begin
      tcnt_d = tcnt_q;
    end
  end

  // A ready slave on the limit cycle still completes normally.
  assign abort_s = (state_q == ACCESS) && !pready && (tcnt_q == CW'(TIMEOUT));

  // Timeout counter register.
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      tcnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_d;
    end
  end
`else
  logic timeout_unused_s;
  assign timeout_unused_s = (TIMEOUT > 0);
  assign abort_s          = 1'b0;
`endif

  // Tie goes to whoever did not win last time.
  assign grant_s = (req0 && req1) ? ~last_owner_q : req1;
  assign done_s  = (state_q == ACCESS) && (pready || abort_s);

  // Next-state and transfer-field capture.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d      = SETUP;
          owner_d      = grant_s;
          last_owner_d = grant_s;
          we_d         = grant_s ? we1 : we0;
          addr_d       = grant_s ? addr1 : addr0;
          wdata_d      = grant_s ? wdata1 : wdata0;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          state_d = IDLE;
          if (!we_q) begin
            rdata_d = prdata;
          end else begin
            rdata_d = rdata_q;
          end
        end else if (abort_s) begin
          state_d = IDLE;
        end else begin
          state_d = ACCESS;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and transfer registers.
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= 16'h0000;
      wdata_q      <= 16'h0000;
      rdata_q      <= 16'h0000;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
    end
  end

  assign psel    = (state_q != IDLE);
  assign penable = (state_q == ACCESS);
  assign pwrite  = we_q;
  assign paddr   = addr_q;
  assign pwdata  = wdata_q;
  assign rdata   = rdata_q;
  assign done0   = done_s && !owner_q;
  assign done1   = done_s && owner_q;
  assign err     = abort_s;

endmodule

// File: tb/tb_apb_ram_arbiter.sv
// Self-checking bench for apb_ram_arbiter: RAM slave model plus transaction-level
// reference (memory image, round-robin winner, last read value).
module tb_apb_ram_arbiter;

  logic        pclk = 1'b0;
  logic        preset = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic [15:0] addr0 = 16'h0, addr1 = 16'h0;
  logic [15:0] wdata0 = 16'h0, wdata1 = 16'h0;
  logic        done0, done1, err;
  logic [15:0] rdata;
  logic        psel, penable, pwrite;
  logic [15:0] paddr, pwdata;
  logic        pready;
  logic [15:0] prdata;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] slave_mem [0:255];
  logic [15:0] ref_mem   [0:255];
  int          slave_waits = 0;
  logic        ref_last;
  logic [15:0] ref_rdata;

  apb_ram_arbiter #(.TIMEOUT(15)) dut (
    .pclk(pclk), .preset(preset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .done0(done0), .done1(done1), .err(err), .rdata(rdata),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pready(pready), .prdata(prdata)
  );

  always #5 pclk = ~pclk;

  // RAM slave: commits writes on the completing edge, inserts slave_waits wait states.
  initial begin
    int acc_cnt;
    acc_cnt = 0;
    pready  = 1'b0;
    prdata  = 16'h0;
    for (int i = 0; i < 256; i++) slave_mem[i] = 16'(i * 37 + 16'h5A00);
    forever begin
      @(posedge pclk);
      if (psel && penable && pready && pwrite) slave_mem[paddr[7:0]] = pwdata;
      #1;
      if (psel && penable) begin
        if (acc_cnt >= slave_waits) begin
          pready = 1'b1;
          prdata = slave_mem[paddr[7:0]];
        end else begin
          pready = 1'b0;
          prdata = 16'($urandom);
        end
        acc_cnt++;
      end else begin
        acc_cnt = 0;
        pready  = 1'b0;
        prdata  = 16'h0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    preset = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    preset    = 1'b1;
    ref_last  = 1'b1;
    ref_rdata = 16'h0;
  endtask

  task automatic wait_done(input int limit, output int cyc, output logic d0, output logic d1, output logic e);
    cyc = -1;
    d0 = 1'b0;
    d1 = 1'b0;
    e = 1'b0;
    for (int i = 1; i <= limit; i++) begin
      @(negedge pclk);
      if (done0 || done1) begin
        cyc = i;
        d0 = done0;
        d1 = done1;
        e = err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge pclk);
    n_tests++;
    if ({psel, penable, pwrite, done0, done1, err} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 000000", {psel, penable, pwrite, done0, done1, err});
    end
    n_tests++;
    if ({paddr, pwdata, rdata} !== 48'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h expected 0", {paddr, pwdata, rdata});
    end
  endtask

  task automatic test_single_write();
    slave_waits = 0;
    @(posedge pclk); #1;
    we0 = 1'b1; addr0 = 16'h0010; wdata0 = 16'hBEEF; req0 = 1'b1;
    @(negedge pclk);
    n_tests++;
    if (psel !== 1'b0) begin n_fail++; $display("FAIL wr_idle_psel: got %b expected 0", psel); end
    @(negedge pclk);
    n_tests++;
    if ({psel, penable, pwrite, paddr, pwdata} !== {3'b101, 16'h0010, 16'hBEEF}) begin
      n_fail++;
      $display("FAIL wr_setup: got %h expected %h", {psel, penable, pwrite, paddr, pwdata}, {3'b101, 16'h0010, 16'hBEEF});
    end
    @(negedge pclk);
    n_tests++;
    if ({psel, penable, pwrite, done0, done1, err, paddr} !== {6'b111100, 16'h0010}) begin
      n_fail++;
      $display("FAIL wr_access: got %h expected %h", {psel, penable, pwrite, done0, done1, err, paddr}, {6'b111100, 16'h0010});
    end
    @(posedge pclk); #1;
    req0 = 1'b0;
    ref_mem[16] = 16'hBEEF;
    ref_last = 1'b0;
    @(negedge pclk);
    n_tests++;
    if (slave_mem[16] !== 16'hBEEF) begin n_fail++; $display("FAIL wr_commit: got %h expected beef", slave_mem[16]); end
  endtask

  task automatic test_wait_read();
    int acc;
    int i;
    slave_waits = 2;
    acc = 0;
    @(posedge pclk); #1;
    we1 = 1'b0; addr1 = 16'h0010; req1 = 1'b1;
    for (i = 1; i <= 20; i++) begin
      @(negedge pclk);
      if (penable) acc++;
      if (done0 || done1) break;
    end
    n_tests++;
    if ({i, acc} !== {32'd5, 32'd3}) begin
      n_fail++;
      $display("FAIL rd_wait_timing: got cycle %0d access %0d expected cycle 5 access 3", i, acc);
    end
    n_tests++;
    if ({done0, done1, err} !== 3'b010) begin
      n_fail++;
      $display("FAIL rd_wait_done: got %b expected 010", {done0, done1, err});
    end
    @(posedge pclk); #1;
    req1 = 1'b0;
    ref_last = 1'b1;
    ref_rdata = 16'hBEEF;
    n_tests++;
    if (rdata !== 16'hBEEF) begin n_fail++; $display("FAIL rd_wait_rdata: got %h expected beef", rdata); end
  endtask

  task automatic test_round_robin();
    logic [15:0] d0v, d1v;
    logic e0, e1;
    slave_waits = 0;
    d0v = 16'($urandom);
    d1v = 16'($urandom);
    @(posedge pclk); #1;
    we0 = 1'b1; addr0 = 16'h0020; wdata0 = d0v;
    we1 = 1'b1; addr1 = 16'h0021; wdata1 = d1v;
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge pclk);
      e0 = (i == 3) || (i == 9);
      e1 = (i == 6) || (i == 12);
      n_tests++;
      if ({done0, done1, err} !== {e0, e1, 1'b0}) begin
        n_fail++;
        $display("FAIL rr_cycle%0d: got %b expected %b", i, {done0, done1, err}, {e0, e1, 1'b0});
      end
    end
    @(posedge pclk); #1;
    req0 = 1'b0; req1 = 1'b0;
    ref_mem[8'h20] = d0v;
    ref_mem[8'h21] = d1v;
    ref_last = 1'b1;
    @(negedge pclk);
    n_tests++;
    if ({slave_mem[8'h20], slave_mem[8'h21]} !== {d0v, d1v}) begin
      n_fail++;
      $display("FAIL rr_mem: got %h expected %h", {slave_mem[8'h20], slave_mem[8'h21]}, {d0v, d1v});
    end
  endtask

  task automatic test_addr_hold();
    int j;
    bit seen;
    slave_waits = 2;
    seen = 1'b0;
    @(posedge pclk); #1;
    we0 = 1'b0; addr0 = 16'h0001; req0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge pclk);
      if (penable) begin seen = 1'b1; break; end
    end
    addr0 = 16'h0002;
    for (j = 0; j < 10; j++) begin
      n_tests++;
      if (paddr !== 16'h0001) begin n_fail++; $display("FAIL hold_paddr: got %h expected 0001", paddr); end
      if (done0) break;
      @(negedge pclk);
    end
    n_tests++;
    if (!(seen && j < 10 && done0 === 1'b1)) begin
      n_fail++;
      $display("FAIL hold_done: got seen=%0d done0=%b expected seen=1 done0=1", seen, done0);
    end
    @(posedge pclk); #1;
    req0 = 1'b0;
    ref_last = 1'b0;
    ref_rdata = ref_mem[1];
    n_tests++;
    if (rdata !== ref_rdata) begin n_fail++; $display("FAIL hold_rdata: got %h expected %h", rdata, ref_rdata); end
  endtask

  task automatic test_random();
    int cyc;
    logic d0, d1, e, w, pend0, pend1;
    logic [15:0] a, wd;
    for (int it = 0; it < 25; it++) begin
      slave_waits = $urandom_range(0, 3);
      pend0 = 1'($urandom);
      pend1 = 1'($urandom);
      if (!pend0 && !pend1) pend0 = 1'b1;
      @(posedge pclk); #1;
      we0 = 1'($urandom); addr0 = 16'($urandom_range(0, 255)); wdata0 = 16'($urandom);
      we1 = 1'($urandom); addr1 = 16'($urandom_range(0, 255)); wdata1 = 16'($urandom);
      req0 = pend0; req1 = pend1;
      while (pend0 || pend1) begin
        w = (pend0 && pend1) ? ~ref_last : pend1;
        wait_done(20, cyc, d0, d1, e);
        n_tests++;
        if ({cyc, d0, d1, e} !== {3 + slave_waits, !w, w, 1'b0}) begin
          n_fail++;
          $display("FAIL rand_done it%0d: got cyc=%0d done=%b%b err=%b expected cyc=%0d done=%b%b err=0",
                   it, cyc, d0, d1, e, 3 + slave_waits, !w, w);
          req0 = 1'b0; req1 = 1'b0;
          apply_reset();
          break;
        end
        a  = w ? addr1 : addr0;
        wd = w ? wdata1 : wdata0;
        if (w ? we1 : we0) ref_mem[a[7:0]] = wd;
        else ref_rdata = ref_mem[a[7:0]];
        ref_last = w;
        @(posedge pclk); #1;
        if (w) begin req1 = 1'b0; pend1 = 1'b0; end
        else begin req0 = 1'b0; pend0 = 1'b0; end
        n_tests++;
        if (rdata !== ref_rdata) begin
          n_fail++;
          $display("FAIL rand_rdata it%0d: got %h expected %h", it, rdata, ref_rdata);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    logic d0, d1, e;
    bit seen;
    bit bad;
    slave_waits = 5;
    seen = 1'b0;
    bad = 1'b0;
    @(posedge pclk); #1;
    we0 = 1'b1; addr0 = 16'h0030; wdata0 = ~ref_mem[8'h30]; req0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge pclk);
      if (penable) begin seen = 1'b1; break; end
    end
    preset = 1'b0;
    #1;
    n_tests++;
    if (!seen || {psel, penable, done0, done1, rdata} !== 20'h0) begin
      n_fail++;
      $display("FAIL rstmid_drop: got seen=%0d %h expected seen=1 0", seen, {psel, penable, done0, done1, rdata});
    end
    repeat (2) begin
      @(negedge pclk);
      if (done0 || done1 || psel) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin n_fail++; $display("FAIL rstmid_quiet: got activity expected none"); end
    @(posedge pclk); #1;
    preset = 1'b1;
    ref_last = 1'b1;
    ref_rdata = 16'h0;
    slave_waits = 0;
    we0 = 1'b0; addr0 = 16'h0030; we1 = 1'b0; addr1 = 16'h0031;
    req0 = 1'b1; req1 = 1'b1;
    wait_done(10, cyc, d0, d1, e);
    n_tests++;
    if ({cyc, d0, d1, e} !== {32'd3, 3'b100}) begin
      n_fail++;
      $display("FAIL rstmid_tie: got cyc=%0d %b expected cyc=3 100", cyc, {d0, d1, e});
    end
    @(posedge pclk); #1;
    req0 = 1'b0;
    n_tests++;
    if (rdata !== ref_mem[8'h30]) begin n_fail++; $display("FAIL rstmid_rd0: got %h expected %h", rdata, ref_mem[8'h30]); end
    wait_done(10, cyc, d0, d1, e);
    @(posedge pclk); #1;
    req1 = 1'b0;
    n_tests++;
    if ({d0, d1, e, rdata} !== {3'b010, ref_mem[8'h31]}) begin
      n_fail++;
      $display("FAIL rstmid_rd1: got %h expected %h", {d0, d1, e, rdata}, {3'b010, ref_mem[8'h31]});
    end
    ref_rdata = ref_mem[8'h31];
    ref_last = 1'b1;
  endtask

  task automatic test_timeout();
    int acc;
    int i;
    bit bad;
    acc = 0;
    bad = 1'b0;
    slave_waits = 100000;
    @(posedge pclk); #1;
    we0 = 1'b0; addr0 = 16'h0040; req0 = 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
    for (i = 1; i <= 40; i++) begin
      @(negedge pclk);
      if (penable) acc++;
      if (done0 || done1) break;
    end
    n_tests++;
    if ({acc, done0, done1, err} !== {32'd16, 3'b101}) begin
      n_fail++;
      $display("FAIL timeout_abort: got access=%0d %b expected access=16 101", acc, {done0, done1, err});
    end
    @(posedge pclk); #1;
    req0 = 1'b0;
    ref_last = 1'b0;
    n_tests++;
    if (rdata !== ref_rdata) begin n_fail++; $display("FAIL timeout_rdata: got %h expected %h", rdata, ref_rdata); end
`else
    for (i = 1; i <= 124; i++) begin
      @(negedge pclk);
      if (penable) acc++;
      if (done0 || done1 || err) bad = 1'b1;
    end
    n_tests++;
    if (bad || acc < 100 || !(psel && penable)) begin
      n_fail++;
      $display("FAIL no_timeout: got access=%0d done_seen=%0d expected access>=100 done_seen=0", acc, bad);
    end
    apply_reset();
`endif
    slave_waits = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 16'(i * 37 + 16'h5A00);
    ref_last = 1'b1;
    ref_rdata = 16'h0;
    test_reset();
    test_single_write();
    test_wait_read();
    test_round_robin();
    test_addr_hold();
    test_random();
    test_reset_mid();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
